// File: rtl/tpg_timing_ctrl_if.sv
// tpg_timing_ctrl_if: shadow-register write port of the test-pattern
// generator timing controller. The master (host) writes shadow registers and
// commits the bank. The slave (controller) reports pending, applied and
// write-error status.
interface tpg_timing_ctrl_if;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        commit;
  logic        pending;
  logic        applied;
  logic        wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, commit,
    input  pending, applied, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit,
    output pending, applied, wr_err
  );
endinterface

// File: rtl/tpg_timing_ctrl.sv
// tpg_timing_ctrl: run controller and timing-bank scheduler for the video
// test-pattern generator. Host writes land in a shadow bank of ten timing
// registers. A committed shadow bank is copied into the active bank as a
// whole: immediately while idle, otherwise only on a frame boundary (rising
// edge of the generator's vsync). A stop request takes effect on the next
// frame boundary.
// Optional feature: define TPG_TIMING_CTRL_FRAME_IRQ_EN to add a sticky
// per-frame interrupt (irq) with a clear input (irq_clr).
module tpg_timing_ctrl #(
  parameter int H_BITS = 12,
  parameter int V_BITS = 12,
  parameter int FCW    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  vs_in,
  tpg_timing_ctrl_if.slave      bus,
  output logic                  tgen_en,
  output logic [H_BITS-1:0]     tHS_START,
  output logic [H_BITS-1:0]     tHS_END,
  output logic [H_BITS-1:0]     tHACT_START,
  output logic [H_BITS-1:0]     tHACT_END,
  output logic [H_BITS-1:0]     tH_END,
  output logic [V_BITS-1:0]     tVS_START,
  output logic [V_BITS-1:0]     tVS_END,
  output logic [V_BITS-1:0]     tVACT_START,
  output logic [V_BITS-1:0]     tVACT_END,
  output logic [V_BITS-1:0]     tV_END,
  output logic [FCW-1:0]        frame_cnt,
  output logic                  busy
`ifdef TPG_TIMING_CTRL_FRAME_IRQ_EN
  ,
  input  logic                  irq_clr,
  output logic                  irq
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              vs_q, vs_d;
  logic              pending_q, pending_d;
  logic              applied_q, applied_d;
  logic              wr_err_q, wr_err_d;
  logic              tgen_en_q, tgen_en_d;
  logic              busy_q, busy_d;
  logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
  logic [H_BITS-1:0] h_shadow_q [5];
  logic [H_BITS-1:0] h_shadow_d [5];
  logic [V_BITS-1:0] v_shadow_q [5];
  logic [V_BITS-1:0] v_shadow_d [5];
  logic [H_BITS-1:0] h_active_q [5];
  logic [H_BITS-1:0] h_active_d [5];
  logic [V_BITS-1:0] v_active_q [5];
  logic [V_BITS-1:0] v_active_d [5];
  logic              fb;
  logic              apply;
`ifdef TPG_TIMING_CTRL_FRAME_IRQ_EN
  logic              irq_q, irq_d;
`endif

  // Upper write-data bits beyond the timing widths carry no meaning.
  logic unused_wr_data;
  assign unused_wr_data = ^bus.wr_data;

  // Next-state logic: frame-boundary detect, bank transfer, shadow writes and run sequencing.
  always_comb begin
    state_d     = state_q;
    vs_d        = vs_in;
    pending_d   = pending_q;
    applied_d   = 1'b0;
    wr_err_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    h_shadow_d  = h_shadow_q;
    v_shadow_d  = v_shadow_q;
    h_active_d  = h_active_q;
    v_active_d  = v_active_q;

    // The edge register keeps tracking vsync while idle, so a vsync that is
    // already high when generation starts does not look like a new frame.
    fb    = vs_in & ~vs_q;
    apply = (state_q == IDLE) ? pending_q : (fb & pending_q);

    // The transfer uses the shadow contents from before this cycle's write.
    if (apply) begin
      h_active_d = h_shadow_q;
      v_active_d = v_shadow_q;
      applied_d  = 1'b1;
      pending_d  = 1'b0;
    end
    if (bus.commit) begin
      pending_d = 1'b1;
    end

    if (bus.wr_en) begin
      if (bus.wr_addr >= 4'd10) begin
        wr_err_d = 1'b1;
      end
      for (int i = 0; i < 5; i++) begin
        if (bus.wr_addr == 4'(i)) begin
          h_shadow_d[i] = bus.wr_data[H_BITS-1:0];
        end
        if (bus.wr_addr == 4'(i + 5)) begin
          v_shadow_d[i] = bus.wr_data[V_BITS-1:0];
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          frame_cnt_d = '0;
        end
      end
      RUN: begin
        if (fb) begin
          frame_cnt_d = frame_cnt_q + FCW'(1);
        end
        if (stop) begin
          state_d = STOPPING;
        end
      end
      STOPPING: begin
        if (fb) begin
          frame_cnt_d = frame_cnt_q + FCW'(1);
        end
        if (start) begin
          state_d = RUN;
        end else if (fb) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    tgen_en_d = (state_d != IDLE);
    busy_d    = (state_d != IDLE);

`ifdef TPG_TIMING_CTRL_FRAME_IRQ_EN
    irq_d = irq_q;
    if (fb && (state_q != IDLE)) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end
`endif
  end

  // State and bank registers; reset clears everything, including both banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vs_q        <= 1'b0;
      pending_q   <= 1'b0;
      applied_q   <= 1'b0;
      wr_err_q    <= 1'b0;
      tgen_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      h_shadow_q  <= '{default: '0};
      v_shadow_q  <= '{default: '0};
      h_active_q  <= '{default: '0};
      v_active_q  <= '{default: '0};
`ifdef TPG_TIMING_CTRL_FRAME_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      vs_q        <= vs_d;
      pending_q   <= pending_d;
      applied_q   <= applied_d;
      wr_err_q    <= wr_err_d;
      tgen_en_q   <= tgen_en_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      h_shadow_q  <= h_shadow_d;
      v_shadow_q  <= v_shadow_d;
      h_active_q  <= h_active_d;
      v_active_q  <= v_active_d;
`ifdef TPG_TIMING_CTRL_FRAME_IRQ_EN
      irq_q       <= irq_d;
`endif
    end
  end

  assign tgen_en     = tgen_en_q;
  assign busy        = busy_q;
  assign frame_cnt   = frame_cnt_q;
  assign bus.pending = pending_q;
  assign bus.applied = applied_q;
  assign bus.wr_err  = wr_err_q;
  assign tHS_START   = h_active_q[0];
  assign tHS_END     = h_active_q[1];
  assign tHACT_START = h_active_q[2];
  assign tHACT_END   = h_active_q[3];
  assign tH_END      = h_active_q[4];
  assign tVS_START   = v_active_q[0];
  assign tVS_END     = v_active_q[1];
  assign tVACT_START = v_active_q[2];
  assign tVACT_END   = v_active_q[3];
  assign tV_END      = v_active_q[4];
`ifdef TPG_TIMING_CTRL_FRAME_IRQ_EN
  assign irq         = irq_q;
`endif

endmodule

// File: tb/tb_tpg_timing_ctrl.sv
// tb_tpg_timing_ctrl: directed vector table, randomized run against a
// behavioural model, frame-counter wrap, mid-run reset and (when enabled)
// the frame interrupt.
module tb_tpg_timing_ctrl;
  localparam int H_BITS = 12;
  localparam int V_BITS = 12;
  localparam int FCW    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, stop, vs_in;
  logic              tgen_en, busy;
  logic [H_BITS-1:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
  logic [V_BITS-1:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
  logic [FCW-1:0]    frame_cnt;
`ifdef TPG_TIMING_CTRL_FRAME_IRQ_EN
  logic              irq, irq_clr;
`endif

  tpg_timing_ctrl_if bus();

  tpg_timing_ctrl #(.H_BITS(H_BITS), .V_BITS(V_BITS), .FCW(FCW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .vs_in(vs_in),
    .bus(bus), .tgen_en(tgen_en),
    .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
    .tHACT_END(tHACT_END), .tH_END(tH_END),
    .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
    .tVACT_END(tVACT_END), .tV_END(tV_END),
    .frame_cnt(frame_cnt), .busy(busy)
`ifdef TPG_TIMING_CTRL_FRAME_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        st, sp, we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        cm, vs;
    logic        en, pend, appl, werr, bsy;
    int          fcnt;
    logic [11:0] hs, he, vss;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: running/stop-requested flags, integer banks.
  bit m_run, m_stopreq, m_pend, m_appl, m_werr, m_irq, m_vsprev;
  int m_fcnt;
  int m_shadow[10];
  int m_active[10];

  function automatic vec_t mk(input logic st, sp, we, input logic [3:0] wa,
                              input logic [15:0] wd, input logic cm, vs,
                              input logic en, pend, appl, werr, bsy,
                              input int fcnt, input logic [11:0] hs, he, vss);
    vec_t v;
    v.st = st; v.sp = sp; v.we = we; v.wa = wa; v.wd = wd; v.cm = cm; v.vs = vs;
    v.en = en; v.pend = pend; v.appl = appl; v.werr = werr; v.bsy = bsy;
    v.fcnt = fcnt; v.hs = hs; v.he = he; v.vss = vss;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, sp, we, input logic [3:0] wa,
                               input logic [15:0] wd, input logic cm, vs, clr);
    start        = st;
    stop         = sp;
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.commit   = cm;
    vs_in        = vs;
`ifdef TPG_TIMING_CTRL_FRAME_IRQ_EN
    irq_clr      = clr;
`else
    if (clr) begin end
`endif
  endtask

  function automatic void modelReset();
    m_run = 0; m_stopreq = 0; m_pend = 0; m_appl = 0; m_werr = 0;
    m_irq = 0; m_vsprev = 0; m_fcnt = 0;
    foreach (m_shadow[i]) begin m_shadow[i] = 0; m_active[i] = 0; end
  endfunction

  function automatic void modelStep(input bit st, sp, we, input int wa, wd,
                                    input bit cm, vs, clr);
    bit fb, was_run, apply;
    fb      = vs && !m_vsprev;
    was_run = m_run;
    apply   = m_run ? (fb && m_pend) : m_pend;
    if (apply) m_active = m_shadow;
    if (we && wa < 10)
      m_shadow[wa] = wd & ((wa < 5) ? ((1 << H_BITS) - 1) : ((1 << V_BITS) - 1));
    m_werr = we && (wa >= 10);
    m_appl = apply;
    if (cm) m_pend = 1;
    else if (apply) m_pend = 0;
    if (!m_run) begin
      if (st) begin m_run = 1; m_stopreq = 0; m_fcnt = 0; end
    end else begin
      if (fb) m_fcnt = (m_fcnt + 1) % (1 << FCW);
      if (m_stopreq) begin
        if (st) m_stopreq = 0;
        else if (fb) m_run = 0;
      end else if (sp) begin
        m_stopreq = 1;
      end
    end
    if (was_run && fb) m_irq = 1;
    else if (clr) m_irq = 0;
    m_vsprev = vs;
  endfunction

  task automatic cycle(input logic st, sp, we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic cm, vs, clr);
    applyStimulus(st, sp, we, wa, wd, cm, vs, clr);
    modelStep(st, sp, we, int'(wa), int'(wd), cm, vs, clr);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dutReg(input int i);
    case (i)
      0: return 32'(tHS_START);
      1: return 32'(tHS_END);
      2: return 32'(tHACT_START);
      3: return 32'(tHACT_END);
      4: return 32'(tH_END);
      5: return 32'(tVS_START);
      6: return 32'(tVS_END);
      7: return 32'(tVACT_START);
      8: return 32'(tVACT_END);
      default: return 32'(tV_END);
    endcase
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, ".tgen_en"}, 32'(tgen_en), 32'(m_run));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(m_run));
    checkOutput({tag, ".pending"}, 32'(bus.pending), 32'(m_pend));
    checkOutput({tag, ".applied"}, 32'(bus.applied), 32'(m_appl));
    checkOutput({tag, ".wr_err"}, 32'(bus.wr_err), 32'(m_werr));
    checkOutput({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_fcnt));
    for (int i = 0; i < 10; i++)
      checkOutput($sformatf("%s.reg%0d", tag, i), dutReg(i), 32'(m_active[i]));
`ifdef TPG_TIMING_CTRL_FRAME_IRQ_EN
    checkOutput({tag, ".irq"}, 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 4'd0, 16'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();
    compareAll("reset");

    // Directed vectors: one row per clock, expected outputs after the edge.
    vecs.push_back(mk(0,0,1,4'd0,16'h010,0,0, 0,0,0,0,0,0,12'h000,12'h000,12'h0));
    vecs.push_back(mk(0,0,1,4'd4,16'h35F,0,0, 0,0,0,0,0,0,12'h000,12'h000,12'h0));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,1,0, 0,1,0,0,0,0,12'h000,12'h000,12'h0));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,0, 0,0,1,0,0,0,12'h010,12'h35F,12'h0));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,0, 0,0,0,0,0,0,12'h010,12'h35F,12'h0));
    vecs.push_back(mk(1,0,0,4'd0,16'h000,0,0, 1,0,0,0,1,0,12'h010,12'h35F,12'h0));
    vecs.push_back(mk(0,0,1,4'd5,16'h007,0,0, 1,0,0,0,1,0,12'h010,12'h35F,12'h0));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,1,0, 1,1,0,0,1,0,12'h010,12'h35F,12'h0));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,0, 1,1,0,0,1,0,12'h010,12'h35F,12'h0));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,1, 1,0,1,0,1,1,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,1, 1,0,0,0,1,1,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,0, 1,0,0,0,1,1,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,1,0,4'd0,16'h000,0,0, 1,0,0,0,1,1,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,0, 1,0,0,0,1,1,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,1, 0,0,0,0,0,2,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,1, 0,0,0,0,0,2,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,0, 0,0,0,0,0,2,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(1,0,0,4'd0,16'h000,0,0, 1,0,0,0,1,0,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,1,0,4'd0,16'h000,0,0, 1,0,0,0,1,0,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(1,0,0,4'd0,16'h000,0,0, 1,0,0,0,1,0,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,1, 1,0,0,0,1,1,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,0, 1,0,0,0,1,1,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,1, 1,0,0,0,1,2,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,0, 1,0,0,0,1,2,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,1,4'd12,16'hABC,0,0, 1,0,0,1,1,2,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,0, 1,0,0,0,1,2,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,1,4'd0,16'h020,1,0, 1,1,0,0,1,2,12'h010,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,1,1, 1,1,1,0,1,3,12'h020,12'h35F,12'h7));
    vecs.push_back(mk(0,0,1,4'd0,16'h030,0,0, 1,1,0,0,1,3,12'h020,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,1, 1,0,1,0,1,4,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,1,0, 1,1,0,0,1,4,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(0,0,1,4'd0,16'h040,0,1, 1,0,1,0,1,5,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,0, 1,0,0,0,1,5,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(1,1,0,4'd0,16'h000,0,0, 1,0,0,0,1,5,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,1, 0,0,0,0,0,6,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(1,1,0,4'd0,16'h000,0,0, 1,0,0,0,1,0,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(0,1,0,4'd0,16'h000,0,0, 1,0,0,0,1,0,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,1, 0,0,0,0,0,1,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(1,0,0,4'd0,16'h000,0,1, 1,0,0,0,1,0,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,1, 1,0,0,0,1,0,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(0,1,0,4'd0,16'h000,0,0, 1,0,0,0,1,0,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,1, 0,0,0,0,0,1,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,1,0, 0,1,0,0,0,1,12'h030,12'h35F,12'h7));
    vecs.push_back(mk(1,0,0,4'd0,16'h000,0,0, 1,0,1,0,1,0,12'h040,12'h35F,12'h7));
    vecs.push_back(mk(0,1,0,4'd0,16'h000,0,0, 1,0,0,0,1,0,12'h040,12'h35F,12'h7));
    vecs.push_back(mk(0,0,0,4'd0,16'h000,0,1, 0,0,0,0,0,1,12'h040,12'h35F,12'h7));
    vecs.push_back(mk(0,1,0,4'd0,16'h000,0,0, 0,0,0,0,0,1,12'h040,12'h35F,12'h7));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].st, vecs[i].sp, vecs[i].we, vecs[i].wa, vecs[i].wd,
            vecs[i].cm, vecs[i].vs, 1'b0);
      checkOutput($sformatf("vec%0d.tgen_en", i), 32'(tgen_en), 32'(vecs[i].en));
      checkOutput($sformatf("vec%0d.pending", i), 32'(bus.pending), 32'(vecs[i].pend));
      checkOutput($sformatf("vec%0d.applied", i), 32'(bus.applied), 32'(vecs[i].appl));
      checkOutput($sformatf("vec%0d.wr_err", i), 32'(bus.wr_err), 32'(vecs[i].werr));
      checkOutput($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
      checkOutput($sformatf("vec%0d.frame_cnt", i), 32'(frame_cnt), 32'(vecs[i].fcnt));
      checkOutput($sformatf("vec%0d.tHS_START", i), 32'(tHS_START), 32'(vecs[i].hs));
      checkOutput($sformatf("vec%0d.tH_END", i), 32'(tH_END), 32'(vecs[i].he));
      checkOutput($sformatf("vec%0d.tVS_START", i), 32'(tVS_START), 32'(vecs[i].vss));
    end

    // Randomized traffic against the behavioural model.
    doReset();
    for (int c = 0; c < 600; c++) begin
      logic r_st, r_sp, r_we, r_cm, r_vs, r_clr;
      logic [3:0] r_wa;
      logic [15:0] r_wd;
      r_st  = ($urandom_range(0, 11) == 0);
      r_sp  = ($urandom_range(0, 13) == 0);
      r_we  = ($urandom_range(0, 2) == 0);
      r_wa  = 4'($urandom_range(0, 15));
      r_wd  = 16'($urandom);
      r_cm  = ($urandom_range(0, 7) == 0);
      r_vs  = ($urandom_range(0, 3) == 0) ? ~vs_in : vs_in;
      r_clr = ($urandom_range(0, 5) == 0);
      cycle(r_st, r_sp, r_we, r_wa, r_wd, r_cm, r_vs, r_clr);
      compareAll($sformatf("rand%0d", c));
    end

    // Frame counter wraps after 2^FCW frames.
    doReset();
    cycle(1, 0, 0, 4'd0, 16'd0, 0, 0, 0);
    for (int f = 0; f < 17; f++) begin
      cycle(0, 0, 0, 4'd0, 16'd0, 0, 1, 0);
      cycle(0, 0, 0, 4'd0, 16'd0, 0, 0, 0);
    end
    checkOutput("wrap.frame_cnt", 32'(frame_cnt), 32'd1);
    checkOutput("wrap.tgen_en", 32'(tgen_en), 32'd1);

    // Mid-run reset clears outputs and banks without waiting for a clock.
    doReset();
    cycle(0, 0, 1, 4'd0, 16'h055, 0, 0, 0);
    cycle(0, 0, 1, 4'd9, 16'h123, 1, 0, 0);
    cycle(0, 0, 0, 4'd0, 16'd0, 0, 0, 0);
    cycle(1, 0, 0, 4'd0, 16'd0, 0, 0, 0);
    checkOutput("midrst.pre_tHS_START", 32'(tHS_START), 32'h055);
    checkOutput("midrst.pre_tV_END", 32'(tV_END), 32'h123);
    rst = 1'b1;
    #2;
    checkOutput("midrst.tgen_en", 32'(tgen_en), 32'd0);
    checkOutput("midrst.busy", 32'(busy), 32'd0);
    checkOutput("midrst.tHS_START", 32'(tHS_START), 32'd0);
    checkOutput("midrst.tV_END", 32'(tV_END), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    // A commit right after reset must transfer an all-zero shadow bank.
    cycle(0, 0, 0, 4'd0, 16'd0, 1, 0, 0);
    cycle(0, 0, 0, 4'd0, 16'd0, 0, 0, 0);
    checkOutput("midrst.applied", 32'(bus.applied), 32'd1);
    checkOutput("midrst.shadow_cleared", 32'(tHS_START), 32'd0);

`ifdef TPG_TIMING_CTRL_FRAME_IRQ_EN
    // Frame interrupt: set on each frame, set wins over clear, lone clear drops it.
    doReset();
    cycle(1, 0, 0, 4'd0, 16'd0, 0, 0, 0);
    checkOutput("irq.idle", 32'(irq), 32'd0);
    cycle(0, 0, 0, 4'd0, 16'd0, 0, 1, 0);
    checkOutput("irq.fb1", 32'(irq), 32'd1);
    cycle(0, 0, 0, 4'd0, 16'd0, 0, 0, 0);
    checkOutput("irq.hold", 32'(irq), 32'd1);
    cycle(0, 0, 0, 4'd0, 16'd0, 0, 1, 0);
    cycle(0, 0, 0, 4'd0, 16'd0, 0, 0, 0);
    cycle(0, 0, 0, 4'd0, 16'd0, 0, 1, 1);
    checkOutput("irq.fb3_with_clr", 32'(irq), 32'd1);
    cycle(0, 0, 0, 4'd0, 16'd0, 0, 0, 1);
    checkOutput("irq.lone_clr", 32'(irq), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
